gemm_sched: RTL and testbench

Run scheduler for the 4-core GEMM engine. It latches a job descriptor, drives the engine's `matw` and `run` levels through a weight-load phase and N input/output batches, and snoops both AXI-Stream handshakes to count beats. It generates the output-stream TLAST and signals done/error to the AXI-Lite register block. It replaces software toggling of the `run`/`matw` bits and sits in the AXIS clock domain, between the register file and the `batch_ctrl`/`ex_ctl`/`out_ctrl` group.

---
 rtl/gemm_pkg.sv | 29 ++
 rtl/gemm_sched_beat_counter.sv | 43 ++++
 rtl/gemm_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_gemm_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM run scheduler: scheduler state encoding,
// default counter widths and the AXI-Lite offsets of the job descriptor.
package gemm_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BATCH_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MATW = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } sched_state_e;

  // Job descriptor layout in the AXI-Lite register block (byte offsets).
  localparam logic [7:0] JOB_REG_CTRL   = 8'h00;  // [0] start, [1] abort
  localparam logic [7:0] JOB_REG_STATUS = 8'h04;  // [0] busy, [1] done, [2] err
  localparam logic [7:0] JOB_REG_WBEATS = 8'h08;
  localparam logic [7:0] JOB_REG_IBEATS = 8'h0C;
  localparam logic [7:0] JOB_REG_OBEATS = 8'h10;
  localparam logic [7:0] JOB_REG_NBATCH = 8'h14;
  localparam logic [7:0] JOB_REG_BIDX   = 8'h18;

  function automatic logic is_busy_state(sched_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/gemm_sched_beat_counter.sv
// Up-counter of accepted stream beats. Clear has priority over increment,
// the count holds once it reaches the limit, and at_last flags the count
// whose next accepted beat is the final one.
module beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_last,
  output logic         full
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign full    = (cnt_q == limit);
  assign at_last = (cnt_q == limit - W'(1));
  assign cnt     = cnt_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !full) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gemm_sched.sv
// Run scheduler for the 4-core GEMM engine. Sequences the matw/run levels
// through a weight-load phase and N batches, snooping both AXIS handshakes.
// Build option: GEMM_SCHED_BATCH_LAST_EN -- when defined, m_last marks the
// final beat of every batch; otherwise only the final beat of the job.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; S beats here are an error
// MATW  | weight load, matw=1, counts wbeats S beats
// GAP   | one cycle with run=matw=0, resets ex_ctl/out_ctrl, clears counters
// RUN   | run=1, input/output beats counted independently
// DONE  | one-cycle done pulse, back to IDLE
module gemm_sched
  import gemm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BATCH_W = BATCH_W_DEF
) (
  input  logic               AXIS_ACLK,
  input  logic               AXIS_ARESETN,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_wbeats,
  input  logic [CNT_W-1:0]   cfg_ibeats,
  input  logic [CNT_W-1:0]   cfg_obeats,
  input  logic [BATCH_W-1:0] cfg_nbatch,
  input  logic               s_valid,
  input  logic               s_ready,
  input  logic               m_valid,
  input  logic               m_ready,
  output logic               matw,
  output logic               run,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BATCH_W-1:0] batch_idx
);

`ifdef GEMM_SCHED_BATCH_LAST_EN
  localparam logic PER_BATCH_LAST = 1'b1;
`else
  localparam logic PER_BATCH_LAST = 1'b0;
`endif

  sched_state_e state_q, state_d;

  logic [CNT_W-1:0]   wbeats_q, wbeats_d;
  logic [CNT_W-1:0]   ibeats_q, ibeats_d;
  logic [CNT_W-1:0]   obeats_q, obeats_d;
  logic [BATCH_W-1:0] nbatch_q, nbatch_d;

  logic matw_q, matw_d;
  logic run_q,  run_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q,  err_d;

  logic s_hs;
  logic m_hs;
  logic cfg_ok;
  logic batch_inc;

  logic               io_clr;
  logic               i_inc;
  logic [CNT_W-1:0]   i_limit;
  logic [CNT_W-1:0]   icnt;
  logic               i_at_last;
  logic               i_full;
  logic               o_inc;
  logic [CNT_W-1:0]   ocnt;
  logic               o_at_last;
  logic               o_full;
  logic               b_clr;
  logic               b_at_last;
  logic               b_full;
  logic               unused_cnt;

  assign s_hs   = s_valid & s_ready;
  assign m_hs   = m_valid & m_ready;
  assign cfg_ok = (cfg_ibeats != '0) && (cfg_obeats != '0) && (cfg_nbatch != '0);

  // The weight phase and the input stream share one counter; the limit
  // follows the phase that is currently counting.
  assign io_clr  = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign i_inc   = s_hs && ((state_q == ST_MATW) || (state_q == ST_RUN));
  assign i_limit = (state_q == ST_MATW) ? wbeats_q : ibeats_q;
  assign o_inc   = m_hs && (state_q == ST_RUN);
  assign b_clr   = (state_d == ST_IDLE);

  beat_counter #(.W(CNT_W)) u_icnt (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .clr     (io_clr),
    .inc     (i_inc),
    .limit   (i_limit),
    .cnt     (icnt),
    .at_last (i_at_last),
    .full    (i_full)
  );

  beat_counter #(.W(CNT_W)) u_ocnt (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .clr     (io_clr),
    .inc     (o_inc),
    .limit   (obeats_q),
    .cnt     (ocnt),
    .at_last (o_at_last),
    .full    (o_full)
  );

  beat_counter #(.W(BATCH_W)) u_bcnt (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .clr     (b_clr),
    .inc     (batch_inc),
    .limit   (nbatch_q),
    .cnt     (batch_idx),
    .at_last (b_at_last),
    .full    (b_full)
  );

  // Raw counts and saturation of the output/batch counters are not needed
  // for sequencing; the terminal-count flags carry all the decisions.
  assign unused_cnt = ^{icnt, ocnt, o_full, b_full};

  // Next state, error flag, descriptor capture and registered output levels.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wbeats_d  = wbeats_q;
    ibeats_d  = ibeats_q;
    obeats_d  = obeats_q;
    nbatch_d  = nbatch_q;
    batch_inc = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              err_d    = 1'b0;
              wbeats_d = cfg_wbeats;
              ibeats_d = cfg_ibeats;
              obeats_d = cfg_obeats;
              nbatch_d = cfg_nbatch;
              state_d  = (cfg_wbeats == '0) ? ST_GAP : ST_MATW;
            end else begin
              err_d = 1'b1;
            end
          end
          if (s_hs) begin
            err_d = 1'b1;
          end
        end
        ST_MATW: begin
          if (s_hs && i_at_last) begin
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (s_hs) begin
            err_d = 1'b1;
          end
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (s_hs && i_full) begin
            err_d = 1'b1;
          end
          if (m_hs && o_at_last) begin
            if (b_at_last) begin
              state_d = ST_DONE;
            end else begin
              batch_inc = 1'b1;
              state_d   = ST_GAP;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    matw_d = (state_d == ST_MATW);
    run_d  = (state_d == ST_RUN);
    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State, latched descriptor and output level registers.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q  <= ST_IDLE;
      wbeats_q <= '0;
      ibeats_q <= '0;
      obeats_q <= '0;
      nbatch_q <= '0;
      matw_q   <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbeats_q <= wbeats_d;
      ibeats_q <= ibeats_d;
      obeats_q <= obeats_d;
      nbatch_q <= nbatch_d;
      matw_q   <= matw_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign matw   = matw_q;
  assign run    = run_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign m_last = (state_q == ST_RUN) && o_at_last && (b_at_last || PER_BATCH_LAST);

endmodule

// File: tb/tb_gemm_sched.sv
module tb_gemm_sched;

  localparam int CW = 16;
  localparam int BW = 16;

`ifdef GEMM_SCHED_BATCH_LAST_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_W    = 1;
  localparam int P_G    = 2;
  localparam int P_R    = 3;
  localparam int P_D    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [CW-1:0] cfg_wbeats = '0, cfg_ibeats = '0, cfg_obeats = '0;
  logic [BW-1:0] cfg_nbatch = '0;
  logic          s_valid = 1'b0, s_ready = 1'b0, m_valid = 1'b0, m_ready = 1'b0;
  logic          matw, run, m_last, busy, done, err;
  logic [BW-1:0] batch_idx;

  always #5 clk = ~clk;

  gemm_sched dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_wbeats   (cfg_wbeats),
    .cfg_ibeats   (cfg_ibeats),
    .cfg_obeats   (cfg_obeats),
    .cfg_nbatch   (cfg_nbatch),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .matw         (matw),
    .run          (run),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .batch_idx    (batch_idx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: job phase plus beats seen so far, updated per cycle.
  int md_ph, md_w_left, md_i, md_o, md_batch;
  int md_wb, md_ib, md_ob, md_nb;
  bit md_err;

  int ob_matw, ob_run, ob_runs, ob_mlast, ob_done;
  bit prev_run;

  typedef struct {
    int wb, ib, ob, nb, pat;
    bit ovr;
    int e_matw, e_run, e_runs, e_mlast, e_done;
    bit e_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit model_mlast();
    return (md_ph == P_R) && (md_o == md_ob - 1) && ((md_batch == md_nb - 1) || PER);
  endfunction

  task automatic model_reset();
    md_ph = P_IDLE; md_w_left = 0; md_i = 0; md_o = 0; md_batch = 0;
    md_wb = 0; md_ib = 0; md_ob = 0; md_nb = 0; md_err = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit s, input bit m);
    if (ab) begin
      md_ph = P_IDLE;
      md_batch = 0;
    end else begin
      case (md_ph)
        P_IDLE: begin
          if (st) begin
            if (cfg_ibeats != 0 && cfg_obeats != 0 && cfg_nbatch != 0) begin
              md_err = 1'b0;
              md_wb = int'(cfg_wbeats); md_ib = int'(cfg_ibeats);
              md_ob = int'(cfg_obeats); md_nb = int'(cfg_nbatch);
              md_w_left = md_wb; md_batch = 0;
              md_ph = (md_wb == 0) ? P_G : P_W;
            end else begin
              md_err = 1'b1;
            end
          end
          if (s) md_err = 1'b1;
        end
        P_W: begin
          if (s) begin
            md_w_left--;
            if (md_w_left == 0) md_ph = P_G;
          end
        end
        P_G: begin
          if (s) md_err = 1'b1;
          md_i = 0; md_o = 0;
          md_ph = P_R;
        end
        P_R: begin
          if (s) begin
            if (md_i == md_ib) md_err = 1'b1;
            else md_i++;
          end
          if (m) begin
            md_o++;
            if (md_o == md_ob) begin
              if (md_batch == md_nb - 1) md_ph = P_D;
              else begin md_batch++; md_ph = P_G; end
            end
          end
        end
        default: begin
          md_ph = P_IDLE;
          md_batch = 0;
        end
      endcase
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input logic st, input logic ab, input logic sv, input logic sr,
                      input logic mv, input logic mr);
    logic [21:0] exp_v;
    exp_v = {(md_ph == P_W), (md_ph == P_R), model_mlast(), (md_ph != P_IDLE),
             (md_ph == P_D), md_err, 16'(md_batch)};
    check("cycle", 32'({matw, run, m_last, busy, done, err, batch_idx}), 32'(exp_v));
    if (matw) ob_matw++;
    if (run) ob_run++;
    if (run && !prev_run) ob_runs++;
    prev_run = run;
    if (m_last && mv && mr) ob_mlast++;
    if (done) ob_done++;
    start = st; abort = ab; s_valid = sv; s_ready = sr; m_valid = mv; m_ready = mr;
    model_step(st, ab, sv && sr, mv && mr);
    @(negedge clk);
  endtask

  // pat: 0 streams always ready, 1 random, 2 m_ready toggling 1010 in RUN.
  task automatic run_job(input int wb, input int ib, input int ob, input int nb, input int pat,
                         input bit ovr, input int ab_batch, input bit noise);
    logic st, ab, sv, sr, mv, mr;
    int rk;
    ob_matw = 0; ob_run = 0; ob_runs = 0; ob_mlast = 0; ob_done = 0; prev_run = 1'b0;
    rk = 0;
    cfg_wbeats = 16'(wb); cfg_ibeats = 16'(ib); cfg_obeats = 16'(ob); cfg_nbatch = 16'(nb);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cfg_wbeats = 16'($urandom); cfg_ibeats = 16'($urandom);
    cfg_obeats = 16'($urandom); cfg_nbatch = 16'($urandom);
    for (int k = 0; k < 2000 && md_ph != P_IDLE; k++) begin
      st = noise && ($urandom_range(0, 7) == 0);
      ab = noise && ($urandom_range(0, 199) == 0);
      sv = 1'b0; sr = 1'b1; mv = 1'b0; mr = 1'b1;
      case (md_ph)
        P_W: begin
          sv = (pat == 1) ? coin() : 1'b1;
          sr = (pat == 1) ? coin() : 1'b1;
        end
        P_G: begin
          if (noise) sv = ($urandom_range(0, 9) == 0);
        end
        P_R: begin
          if (ovr) sv = 1'b1;
          else sv = (md_i < md_ib) && ((pat != 1) || coin());
          sr = (pat == 1) ? coin() : 1'b1;
          mv = (pat == 1) ? coin() : 1'b1;
          mr = (pat == 2) ? (rk % 2 == 0) : ((pat == 1) ? coin() : 1'b1);
          rk++;
          if (ab_batch >= 0 && md_batch == ab_batch) ab = 1'b1;
        end
        default: ;
      endcase
      tick(st, ab, sv, sr, mv, mr);
    end
    check("job_bound_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    vecs[0] = '{8, 16, 4, 1, 0, 1'b0, 8, 4, 1, 1, 1, 1'b0};
    vecs[1] = '{0,  2, 2, 3, 0, 1'b0, 0, 6, 3, (PER ? 3 : 1), 1, 1'b0};
    vecs[2] = '{0,  3, 5, 1, 2, 1'b0, 0, 9, 1, 1, 1, 1'b0};
    vecs[3] = '{2,  3, 2, 0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1};
    vecs[4] = '{2,  1, 1, 1, 0, 1'b0, 2, 1, 1, 1, 1, 1'b0};
    vecs[5] = '{0,  4, 8, 1, 0, 1'b1, 0, 8, 1, 1, 1, 1'b1};
    vecs[6] = '{1,  1, 1, 2, 0, 1'b0, 1, 2, 2, (PER ? 2 : 1), 1, 1'b0};
    vecs[7] = '{0,  0, 3, 1, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1};
    vecs[8] = '{3,  2, 0, 2, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1};

    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_matw", 32'(matw), 32'(0));
    check("reset_run", 32'(run), 32'(0));
    check("reset_m_last", 32'(m_last), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_batch_idx", 32'(batch_idx), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // start and abort together: abort wins, nothing starts
    cfg_wbeats = 16'd2; cfg_ibeats = 16'd1; cfg_obeats = 16'd1; cfg_nbatch = 16'd1;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("start_abort_busy", 32'(busy), 32'(0));
    check("start_abort_matw", 32'(matw), 32'(0));

    for (int v = 0; v < 9; v++) begin
      run_job(vecs[v].wb, vecs[v].ib, vecs[v].ob, vecs[v].nb, vecs[v].pat, vecs[v].ovr, -1, 1'b0);
      check($sformatf("vec%0d_matw_cycles", v), 32'(ob_matw), 32'(vecs[v].e_matw));
      check($sformatf("vec%0d_run_cycles", v), 32'(ob_run), 32'(vecs[v].e_run));
      check($sformatf("vec%0d_run_phases", v), 32'(ob_runs), 32'(vecs[v].e_runs));
      check($sformatf("vec%0d_m_last_beats", v), 32'(ob_mlast), 32'(vecs[v].e_mlast));
      check($sformatf("vec%0d_done_pulses", v), 32'(ob_done), 32'(vecs[v].e_done));
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].e_err));
    end

    // abort in the first RUN cycle of the second batch of four
    run_job(1, 1, 2, 4, 0, 1'b0, 1, 1'b0);
    check("abort_run", 32'(run), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_batch_idx", 32'(batch_idx), 32'(0));
    check("abort_no_done", 32'(ob_done), 32'(0));
    check("abort_run_phases", 32'(ob_runs), 32'(2));
    run_job(0, 1, 2, 2, 0, 1'b0, -1, 1'b0);
    check("after_abort_done", 32'(ob_done), 32'(1));
    check("after_abort_run_phases", 32'(ob_runs), 32'(2));

    // randomized jobs with stray starts, stray S beats and occasional aborts
    for (int j = 0; j < 30; j++) begin
      int wb, ib, ob, nb, abb;
      wb = $urandom_range(0, 4);
      ib = $urandom_range(1, 4);
      ob = $urandom_range(1, 4);
      nb = $urandom_range(1, 3);
      abb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
      run_job(wb, ib, ob, nb, 1, ($urandom_range(0, 3) == 0), abb, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
